// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU among NUM_REQ requesters,
// keeping exactly one request in flight and returning its result to the owner.
module alu_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                   clock_in,
   input  logic                   reset_in,
   input  logic [NUM_REQ-1:0]     req_valid_in,
   input  logic [3*NUM_REQ-1:0]   req_opcode_in,
   input  logic [8*NUM_REQ-1:0]   req_operand1_in,
   input  logic [8*NUM_REQ-1:0]   req_operand2_in,
   output logic [NUM_REQ-1:0]     req_ready_out,
   output logic [NUM_REQ-1:0]     resp_valid_out,
   input  logic [NUM_REQ-1:0]     resp_ready_in,
   output logic [7:0]             resp_data_out,
   output logic                   resp_error_out,
   output logic                   alu_enable_out,
   output logic [2:0]             alu_opcode_out,
   output logic [7:0]             alu_input1_out,
   output logic [7:0]             alu_input2_out,
   input  logic [7:0]             alu_result_in
);

   localparam int unsigned IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [2:0]  LAST_LEGAL_OP = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   hi_win;
   logic [IDX_W-1:0]   lo_win;
   logic [IDX_W-1:0]   next_ptr;
   logic               hi_any;
   logic               any_valid;
   logic [NUM_REQ-1:0] win_onehot;
   logic [NUM_REQ-1:0] owner_onehot;
   logic               owner_ready;
   logic [2:0]         win_opcode;
   logic [7:0]         win_op1;
   logic [7:0]         win_op2;

   // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall
   always_comb begin
      hi_any    = 1'b0;
      any_valid = 1'b0;
      hi_win    = '0;
      lo_win    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_in[i]) begin
            any_valid = 1'b1;
            lo_win    = IDX_W'(i);
            if (IDX_W'(i) >= ptr) begin
               hi_any = 1'b1;
               hi_win = IDX_W'(i);
            end
         end
      end
      win      = hi_any ? hi_win : lo_win;
      next_ptr = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
   end

   // Winner payload mux and owner decode
   always_comb begin
      win_opcode   = '0;
      win_op1      = '0;
      win_op2      = '0;
      win_onehot   = '0;
      owner_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win == IDX_W'(k)) begin
            win_opcode    = req_opcode_in[3*k +: 3];
            win_op1       = req_operand1_in[8*k +: 8];
            win_op2       = req_operand2_in[8*k +: 8];
            win_onehot[k] = any_valid;
         end
         owner_onehot[k] = (owner == IDX_W'(k));
      end
      owner_ready = |(resp_ready_in & owner_onehot);
   end

   // Grant strobe is combinational and only offered while idle
   assign req_ready_out = (state == S_IDLE && !reset_in) ? win_onehot : '0;

   // Request lifecycle: accept, issue to ALU, capture result, hand back to owner
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state          <= S_IDLE;
         ptr            <= '0;
         owner          <= '0;
         alu_enable_out <= 1'b0;
         alu_opcode_out <= '0;
         alu_input1_out <= '0;
         alu_input2_out <= '0;
         resp_valid_out <= '0;
         resp_data_out  <= '0;
         resp_error_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_valid) begin
                  owner          <= win;
                  ptr            <= next_ptr;
                  alu_opcode_out <= win_opcode;
                  alu_input1_out <= win_op1;
                  alu_input2_out <= win_op2;
                  alu_enable_out <= (win_opcode <= LAST_LEGAL_OP);
                  state          <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               alu_enable_out <= 1'b0;
               if (alu_opcode_out <= LAST_LEGAL_OP) begin
                  state <= S_WAIT;
               end else begin
                  resp_data_out  <= '0;
                  resp_error_out <= 1'b1;
                  resp_valid_out <= owner_onehot;
                  state          <= S_RESP;
               end
            end
            S_WAIT: begin
               resp_data_out  <= alu_result_in;
               resp_error_out <= 1'b0;
               resp_valid_out <= owner_onehot;
               state          <= S_RESP;
            end
            S_RESP: begin
               if (owner_ready) begin
                  resp_valid_out <= '0;
                  resp_data_out  <= '0;
                  resp_error_out <= 1'b0;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
